// File: rtl/capture_sequencer_if.sv
// ============================================================================
// Module      : capture_sequencer_if
// Description : Signal bundle between the capture sequencer and the harness
//               (start button, DUT reset, capture RAM write side, readout).
//               master : the sequencer (drives capture/status outputs)
//               slave  : the surrounding harness (drives button/transfer_done)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface capture_sequencer_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int RUN_WIDTH     = 8
);
    logic                     UserPushButton1;
    logic                     transfer_done;
    logic                     enable;
    logic [ADDRESS_WIDTH-1:0] capture_addr;
    logic                     dut_reset;
    logic                     start_signal;
    logic [RUN_WIDTH-1:0]     run_index;
    logic                     done;
    logic                     error;

    modport master (
        input  UserPushButton1,
        input  transfer_done,
        output enable,
        output capture_addr,
        output dut_reset,
        output start_signal,
        output run_index,
        output done,
        output error
    );

    modport slave (
        output UserPushButton1,
        output transfer_done,
        input  enable,
        input  capture_addr,
        input  dut_reset,
        input  start_signal,
        input  run_index,
        input  done,
        input  error
    );
endinterface

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ============================================================================
// Module      : capture_sequencer
// Description : Multi-run capture controller. On a button press it pulses the
//               DUT reset, opens a capture window of MAX_RAM_ADDRESS-2 cycles
//               with an incrementing RAM address, waits for the readout engine
//               to report transfer_done, and repeats for NUM_RUNS runs before
//               parking in DONE.
// Ports       : variable_clk_2 - single clock, rising edge
//               reset          - asynchronous, active-high
//               bus (master)   - UserPushButton1, transfer_done in;
//                                enable, capture_addr, dut_reset,
//                                start_signal, run_index, done, error out
// Options     : CAPTURE_SEQ_TIMEOUT_EN - adds a transfer watchdog and an
//               ERROR state; when undefined, error is tied low and WAIT_XFER
//               waits indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_sequencer #(
    parameter int ADDRESS_WIDTH   = 14,
    parameter int MAX_RAM_ADDRESS = 16384,
    parameter int NUM_RUNS        = 4,
    parameter int RUN_WIDTH       = 8,
    parameter int RESET_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input wire                  variable_clk_2,
    input wire                  reset,
    capture_sequencer_if.master bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (MAX_RAM_ADDRESS < 3 || MAX_RAM_ADDRESS > (1 << ADDRESS_WIDTH)) begin : g_bad_ram_depth
        $error("capture_sequencer: MAX_RAM_ADDRESS out of range");
    end
    if (NUM_RUNS < 1 || NUM_RUNS > (1 << RUN_WIDTH)) begin : g_bad_num_runs
        $error("capture_sequencer: NUM_RUNS out of range");
    end
    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("capture_sequencer: RESET_CYCLES/TIMEOUT_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_rst_cnt_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [c_rst_cnt_w-1:0]   c_rst_last = c_rst_cnt_w'(RESET_CYCLES - 1);
    localparam logic [c_rst_cnt_w-1:0]   c_rst_inc  = c_rst_cnt_w'(1);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_last = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 3);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_inc  = ADDRESS_WIDTH'(1);
    localparam logic [RUN_WIDTH-1:0]     c_run_last  = RUN_WIDTH'(NUM_RUNS - 1);
    localparam logic [RUN_WIDTH-1:0]     c_run_inc   = RUN_WIDTH'(1);

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam int c_wd_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wd_cnt_w-1:0] c_wd_last = c_wd_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_wd_cnt_w-1:0] c_wd_inc  = c_wd_cnt_w'(1);
`endif

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RESET_PULSE = 3'd1,
        CAPTURE     = 3'd2,
        WAIT_XFER   = 3'd3,
        DONE        = 3'd4
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        , ERROR     = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     prev_q, prev_d;
    logic [c_rst_cnt_w-1:0]   rst_cnt_q, rst_cnt_d;
    logic [ADDRESS_WIDTH-1:0] capture_addr_q, capture_addr_d;
    logic [RUN_WIDTH-1:0]     run_index_q, run_index_d;
    logic                     enable_q, enable_d;
    logic                     dut_reset_q, dut_reset_d;
    logic                     start_signal_q, start_signal_d;
    logic                     done_q, done_d;
    logic                     press;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [c_wd_cnt_w-1:0]    wd_cnt_q, wd_cnt_d;
    logic                     error_q, error_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        sync1_d        = bus.UserPushButton1;
        sync2_d        = sync1_q;
        prev_d         = sync2_q;
        press          = sync2_q & ~prev_q;

        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        capture_addr_d = capture_addr_q;
        run_index_d    = run_index_q;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        wd_cnt_d       = wd_cnt_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (press) begin
                    state_d     = RESET_PULSE;
                    run_index_d = '0;
                    rst_cnt_d   = '0;
                end
            end
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            ERROR: begin
                if (press) begin
                    state_d     = RESET_PULSE;
                    run_index_d = '0;
                    rst_cnt_d   = '0;
                end
            end
`endif
            RESET_PULSE: begin
                if (rst_cnt_q == c_rst_last) begin
                    state_d        = CAPTURE;
                    capture_addr_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + c_rst_inc;
                end
            end
            CAPTURE: begin
                // The address stops on the last location so it reads back as
                // the final written address while the readout runs.
                if (capture_addr_q == c_addr_last) begin
                    state_d = WAIT_XFER;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    capture_addr_d = capture_addr_q + c_addr_inc;
                end
            end
            WAIT_XFER: begin
                // transfer_done is checked before the watchdog so that it wins
                // when both land in the same cycle.
                if (bus.transfer_done) begin
                    if (run_index_q == c_run_last) begin
                        state_d = DONE;
                    end else begin
                        state_d     = RESET_PULSE;
                        run_index_d = run_index_q + c_run_inc;
                        rst_cnt_d   = '0;
                    end
                end
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                else if (wd_cnt_q == c_wd_last) begin
                    state_d = ERROR;
                end else begin
                    wd_cnt_d = wd_cnt_q + c_wd_inc;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state itself.
        enable_d       = (state_d == CAPTURE);
        dut_reset_d    = (state_d == RESET_PULSE);
        start_signal_d = (state_d == IDLE);
        done_d         = (state_d == DONE);
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        error_d        = (state_d == ERROR);
`endif
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge variable_clk_2 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            rst_cnt_q      <= '0;
            capture_addr_q <= '0;
            run_index_q    <= '0;
            enable_q       <= 1'b0;
            dut_reset_q    <= 1'b0;
            start_signal_q <= 1'b1;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            rst_cnt_q      <= rst_cnt_d;
            capture_addr_q <= capture_addr_d;
            run_index_q    <= run_index_d;
            enable_q       <= enable_d;
            dut_reset_q    <= dut_reset_d;
            start_signal_q <= start_signal_d;
            done_q         <= done_d;
        end
    end

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    always_ff @(posedge variable_clk_2 or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.enable       = enable_q;
    assign bus.capture_addr = capture_addr_q;
    assign bus.dut_reset    = dut_reset_q;
    assign bus.start_signal = start_signal_q;
    assign bus.run_index    = run_index_q;
    assign bus.done         = done_q;

endmodule

`default_nettype wire

// File: doc/capture_sequencer.md
# capture_sequencer

Multi-run capture controller for the high-radix online arithmetic test harness. It gates a RAM capture window (`enable` plus write address), waits for the readout engine to report `transfer_done`, then pulses the DUT reset before the next run. It repeats for `NUM_RUNS` runs and then parks in DONE. It sits between the push-button start input, the DUT, and the capture RAM/transfer logic.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 14: width of the capture address.
- `MAX_RAM_ADDRESS`, 16384: RAM depth. The capture window is `MAX_RAM_ADDRESS-2` cycles long. Must satisfy 3 ≤ `MAX_RAM_ADDRESS` ≤ 2^`ADDRESS_WIDTH`.
- `NUM_RUNS`, 4: runs per start command, ≥1.
- `RUN_WIDTH`, 8: width of `run_index`. `NUM_RUNS` ≤ 2^`RUN_WIDTH`.
- `RESET_CYCLES`, 4: length of the DUT reset pulse, ≥1.
- `TIMEOUT_CYCLES`, 1024: transfer watchdog limit, ≥1. Used only with `CAPTURE_SEQ_TIMEOUT_EN`.

Ports:
- `variable_clk_2`, in, 1: the single clock. All logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `UserPushButton1`, in, 1: raw start button, asynchronous to the clock.
- `transfer_done`, in, 1: readout complete. Sampled only in WAIT_XFER.
- `enable`, out, 1: capture window active.
- `capture_addr`, out, `ADDRESS_WIDTH`: RAM write address. Valid while `enable` is high.
- `dut_reset`, out, 1: reset pulse to the DUT.
- `start_signal`, out, 1: high only in IDLE.
- `run_index`, out, `RUN_WIDTH`: index of the current run.
- `done`, out, 1: all runs complete.
- `error`, out, 1: transfer watchdog expired.

## Operation
- Button input passes through a 2-flop synchroniser plus a previous-value flop. A press is the rising edge of the synchronised value (`sync2 & ~prev`).
- States and transitions:
  - IDLE: on press → RESET_PULSE, `run_index` = 0.
  - RESET_PULSE: `dut_reset` = 1 for exactly `RESET_CYCLES` cycles, then → CAPTURE.
  - CAPTURE: `enable` = 1. `capture_addr` counts 0 .. `MAX_RAM_ADDRESS-3`, incrementing by 1 per cycle. After the last address → WAIT_XFER.
  - WAIT_XFER: `enable` = 0, `capture_addr` holds its last value.
    - On `transfer_done`, if `run_index` = `NUM_RUNS-1` → DONE.
    - On `transfer_done` otherwise, `run_index` increments → RESET_PULSE.
  - DONE: `done` = 1. On press → RESET_PULSE, `run_index` = 0, `done` cleared.
  - ERROR (macro builds only): `error` = 1. On press → RESET_PULSE, `run_index` = 0, `error` cleared.
- Presses in RESET_PULSE, CAPTURE and WAIT_XFER are ignored, not queued.
- `transfer_done` outside WAIT_XFER is ignored.
- Address and run arithmetic is unsigned and never wraps within a run. `capture_addr` resets to 0 on entry to CAPTURE.

## Timing
- Reset values of outputs: `enable` 0, `capture_addr` 0, `dut_reset` 0, `start_signal` 1, `run_index` 0, `done` 0, `error` 0. State resets to IDLE.
- Reset values of internal flops: synchroniser and previous-value flops 0. A button held through reset therefore counts as one press after reset deasserts.
- Reset asserted mid-operation aborts immediately, asynchronously, to the values above.
- All outputs are registered, with no combinational input→output paths.
- Button latency: button high at edge k → `dut_reset` = 1 and `start_signal` = 0 after edge k+2.
- `enable` rises on the edge where `dut_reset` falls, with no gap cycle.
- `enable` stays high for exactly `MAX_RAM_ADDRESS-2` cycles. `capture_addr` = 0 in the first of those cycles.
- `transfer_done` high at edge j in WAIT_XFER → next state, and `done` or `dut_reset`, visible after edge j.
- The earliest `transfer_done` accepted is the first cycle after `enable` falls.

## Configuration
- `CAPTURE_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to WAIT_XFER.
  - If `transfer_done` is not seen within `TIMEOUT_CYCLES` cycles in WAIT_XFER → ERROR, `error` = 1.
  - If `transfer_done` arrives in the same cycle the limit is reached, `transfer_done` wins.
- Macro undefined: no watchdog, no ERROR state. `error` is tied to 0 and WAIT_XFER waits indefinitely.

## Test plan
- Defaults, reset, then button high for 10 cycles → `dut_reset` high 4 cycles starting 2 edges later, then `enable` high for 16382 cycles with addresses 0..16381, one press only.
- `NUM_RUNS`=3, `MAX_RAM_ADDRESS`=8, `transfer_done` pulsed 5 cycles after each window → 3 reset pulses and 3 windows of 6 cycles, `run_index` 0,1,2, then `done`=1.
- `transfer_done` pulsed during CAPTURE and again in DONE, plus button pulses during CAPTURE → no state change, no extra run.
- `reset` asserted mid-CAPTURE at address 3 → all outputs at reset values immediately. The next press restarts at `run_index` 0, address 0.
- With macro, `TIMEOUT_CYCLES`=16, no `transfer_done` → `error`=1 after 16 WAIT_XFER cycles. A press then → RESET_PULSE with `error`=0. A separate run with `transfer_done` on cycle 16 → no error.
- Button held high through reset release → exactly one run sequence starts, 3 edges after deassertion.
